// File: rtl/timing_sequencer_if.sv
// -----------------------------------------------------------------------------
// timing_sequencer_if
//   Bundles the control and status signals of the timing sequencer so that the
//   core and whatever drives it share one port list.
//
//   Control (master -> slave):
//     start      one-cycle request to set the run flip-flop
//     halt       clear run and the sequence counter at the next edge
//     ir_opcode  IR[14:12], sampled at the end of T2
//     ir_i       IR[15] indirect bit, sampled at the end of T2
//     exec_done  execute phase finished; restart at T0
//   Status (slave -> master):
//     run        S flip-flop
//     t_out      one-hot timing T0..T(2**SC_WIDTH-1), all zero while halted
//     d_out      one-hot decode of the latched opcode
//     i_ff       latched indirect bit
//     ar_ld_pc   AR <- PC           (T0)
//     ir_ld      IR <- M[AR]        (T1)
//     pc_inc     PC <- PC + 1       (T1)
//     ar_ld_ir   AR <- IR[11:0]     (T2)
//     ar_ld_mem  AR <- M[AR]        (T3, memory-reference, indirect)
//     exec_en    execute phase active
//     sc_err     sticky: sequence counter wrapped without exec_done
// -----------------------------------------------------------------------------
interface timing_sequencer_if #(
  parameter int SC_WIDTH  = 4,
  parameter int OPC_WIDTH = 3
);
  logic                       start;
  logic                       halt;
  logic [OPC_WIDTH-1:0]       ir_opcode;
  logic                       ir_i;
  logic                       exec_done;

  logic                       run;
  logic [(2**SC_WIDTH)-1:0]   t_out;
  logic [(2**OPC_WIDTH)-1:0]  d_out;
  logic                       i_ff;
  logic                       ar_ld_pc;
  logic                       ir_ld;
  logic                       pc_inc;
  logic                       ar_ld_ir;
  logic                       ar_ld_mem;
  logic                       exec_en;
  logic                       sc_err;

  // Side that issues control and observes status.
  modport master (
    output start, halt, ir_opcode, ir_i, exec_done,
    input  run, t_out, d_out, i_ff, ar_ld_pc, ir_ld, pc_inc,
           ar_ld_ir, ar_ld_mem, exec_en, sc_err
  );

  // The sequencer core.
  modport slave (
    input  start, halt, ir_opcode, ir_i, exec_done,
    output run, t_out, d_out, i_ff, ar_ld_pc, ir_ld, pc_inc,
           ar_ld_ir, ar_ld_mem, exec_en, sc_err
  );
endinterface

// File: rtl/timing_sequencer.sv
// -----------------------------------------------------------------------------
// timing_sequencer
//   Control-unit timing core of the basic computer. Holds the start/stop
//   flip-flop S (as a two-state FSM), the sequence counter SC, the opcode
//   decode register D and the indirect flip-flop I, and produces the one-hot
//   timing vector plus the fetch / decode / indirect register enables.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; clears all state
//     bus    timing_sequencer_if.slave (control in, timing/enables out)
// -----------------------------------------------------------------------------
module timing_sequencer #(
  parameter int SC_WIDTH  = 4,
  parameter int OPC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  timing_sequencer_if.slave    bus
);

  localparam int T_W = 2 ** SC_WIDTH;
  localparam int D_W = 2 ** OPC_WIDTH;
  // Highest opcode (all ones) selects register/IO instructions.
  localparam int D_REGIO = D_W - 1;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [SC_WIDTH-1:0] sc_reg, sc_next;
  logic [D_W-1:0]      d_reg, d_next;
  logic                i_reg, i_next;
  logic                err_reg, err_next;

  logic                running;
  logic [T_W-1:0]      t_vec;
  logic                sc_at_end;

  assign running   = (state_reg == ST_RUN);
  assign sc_at_end = (sc_reg == {SC_WIDTH{1'b1}});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_STOP;
      sc_reg    <= '0;
      d_reg     <= '0;
      i_reg     <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sc_reg    <= sc_next;
      d_reg     <= d_next;
      i_reg     <= i_next;
      err_reg   <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    sc_next    = '0;
    d_next     = d_reg;
    i_next     = i_reg;
    err_next   = err_reg;

    unique case (state_reg)
      ST_STOP: begin
        // halt wins over start; SC stays parked at 0 while stopped.
        if (bus.start && !bus.halt) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.halt) begin
          state_next = ST_STOP;
        end else if (bus.exec_done) begin
          // Also covers an abort during fetch (SC < 3): back to T0 without
          // touching the decode register.
          sc_next = '0;
        end else begin
          sc_next = sc_reg + 1'b1;
          if (sc_at_end) begin
            err_next = 1'b1;
          end
          // Edge ending T2 captures the instruction decode.
          if (sc_reg == SC_WIDTH'(2)) begin
            d_next = D_W'(1) << bus.ir_opcode;
            i_next = bus.ir_i;
          end
        end
      end

      default: begin
        state_next = ST_STOP;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One-hot timing decode: purely from registers, so no input reaches an
  // output combinationally.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < T_W; gi++) begin : g_tdec
      assign t_vec[gi] = running && (sc_reg == SC_WIDTH'(gi));
    end
  endgenerate

  assign bus.run       = running;
  assign bus.t_out     = t_vec;
  assign bus.d_out     = d_reg;
  assign bus.i_ff      = i_reg;
  assign bus.sc_err    = err_reg;

  // Fetch and decode enables. T0/T2/T3 are mutually exclusive, so at most
  // one AR load fires in any cycle.
  assign bus.ar_ld_pc  = t_vec[0];
  assign bus.ir_ld     = t_vec[1];
  assign bus.pc_inc    = t_vec[1];
  assign bus.ar_ld_ir  = t_vec[2];
  assign bus.ar_ld_mem = t_vec[3] && !d_reg[D_REGIO] && i_reg;

  // Register/IO instructions execute from T3; memory-reference ones need T3
  // for the indirect cycle and start executing at T4.
  assign bus.exec_en   = running &&
                         ( ( d_reg[D_REGIO] && (sc_reg >= SC_WIDTH'(3))) ||
                           (!d_reg[D_REGIO] && (sc_reg >= SC_WIDTH'(4))) );

endmodule

// File: tb/tb_timing_sequencer.sv
// -----------------------------------------------------------------------------
// tb_timing_sequencer
//   Table-driven bench for timing_sequencer plus hand sequences for the
//   counter wrap / sticky error and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timing_sequencer;

  logic clk;
  logic reset;

  timing_sequencer_if #(.SC_WIDTH(4), .OPC_WIDTH(3)) bus ();

  timing_sequencer #(.SC_WIDTH(4), .OPC_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One row: inputs held for one cycle, then outputs expected after that edge.
  typedef struct packed {
    logic        start;
    logic        halt;
    logic        done;
    logic [2:0]  opc;
    logic        ir_i;
    logic        e_run;
    logic [15:0] e_t;
    logic [7:0]  e_d;
    logic        e_i;
    logic        e_mem;
    logic        e_exec;
    logic        e_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic drive(input logic s, input logic h, input logic d,
                       input logic [2:0] o, input logic i);
    bus.start     = s;
    bus.halt      = h;
    bus.exec_done = d;
    bus.ir_opcode = o;
    bus.ir_i      = i;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".run"},       32'(bus.run),       32'(v.e_run));
    check({tag, ".t_out"},     32'(bus.t_out),     32'(v.e_t));
    check({tag, ".d_out"},     32'(bus.d_out),     32'(v.e_d));
    check({tag, ".i_ff"},      32'(bus.i_ff),      32'(v.e_i));
    check({tag, ".ar_ld_mem"}, 32'(bus.ar_ld_mem), 32'(v.e_mem));
    check({tag, ".exec_en"},   32'(bus.exec_en),   32'(v.e_exec));
    check({tag, ".sc_err"},    32'(bus.sc_err),    32'(v.e_err));
    check({tag, ".ar_ld_pc"},  32'(bus.ar_ld_pc),  32'(v.e_t[0]));
    check({tag, ".ir_ld"},     32'(bus.ir_ld),     32'(v.e_t[1]));
    check({tag, ".pc_inc"},    32'(bus.pc_inc),    32'(v.e_t[1]));
    check({tag, ".ar_ld_ir"},  32'(bus.ar_ld_ir),  32'(v.e_t[2]));
  endtask

  initial begin
    //            st h  dn opc    i  run t_out     d_out  i  mem ex err
    vecs[0]  = '{1'b1,1'b0,1'b0,3'b010,1'b0, 1'b1,16'h0001,8'h00,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,3'b010,1'b0, 1'b1,16'h0002,8'h00,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,3'b010,1'b0, 1'b1,16'h0004,8'h00,1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,3'b010,1'b0, 1'b1,16'h0008,8'h04,1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,3'b010,1'b0, 1'b1,16'h0010,8'h04,1'b0,1'b0,1'b1,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,3'b010,1'b0, 1'b1,16'h0020,8'h04,1'b0,1'b0,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,3'b010,1'b0, 1'b1,16'h0001,8'h04,1'b0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,3'b001,1'b1, 1'b1,16'h0002,8'h04,1'b0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,3'b001,1'b1, 1'b1,16'h0004,8'h04,1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,3'b001,1'b1, 1'b1,16'h0008,8'h02,1'b1,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,3'b001,1'b1, 1'b1,16'h0010,8'h02,1'b1,1'b0,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,3'b001,1'b1, 1'b1,16'h0001,8'h02,1'b1,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,3'b111,1'b1, 1'b1,16'h0002,8'h02,1'b1,1'b0,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,3'b111,1'b1, 1'b1,16'h0004,8'h02,1'b1,1'b0,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b0,3'b111,1'b1, 1'b1,16'h0008,8'h80,1'b1,1'b0,1'b1,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b0,3'b111,1'b1, 1'b0,16'h0000,8'h80,1'b1,1'b0,1'b0,1'b0};
    vecs[16] = '{1'b1,1'b1,1'b0,3'b111,1'b1, 1'b0,16'h0000,8'h80,1'b1,1'b0,1'b0,1'b0};
    vecs[17] = '{1'b1,1'b0,1'b0,3'b000,1'b0, 1'b1,16'h0001,8'h80,1'b1,1'b0,1'b0,1'b0};
    vecs[18] = '{1'b1,1'b0,1'b0,3'b000,1'b0, 1'b1,16'h0002,8'h80,1'b1,1'b0,1'b0,1'b0};
    vecs[19] = '{1'b0,1'b0,1'b1,3'b000,1'b0, 1'b1,16'h0001,8'h80,1'b1,1'b0,1'b0,1'b0};

    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("reset.run",    32'(bus.run),    32'd0);
    check("reset.t_out",  32'(bus.t_out),  32'd0);
    check("reset.d_out",  32'(bus.d_out),  32'd0);
    check("reset.sc_err", 32'(bus.sc_err), 32'd0);
    $display("txn reset: run=%0b t=%04h d=%02h", bus.run, bus.t_out, bus.d_out);

    // Table: fetch/decode/execute for opcodes 010, 001(I), 111(I) + halt,
    // start/halt collision, start while running, early exec_done abort.
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].start, vecs[k].halt, vecs[k].done, vecs[k].opc, vecs[k].ir_i);
      step();
      check_all($sformatf("vec%0d", k), vecs[k]);
      $display("txn vec%0d: run=%0b t=%04h d=%02h i=%0b mem=%0b ex=%0b err=%0b",
               k, bus.run, bus.t_out, bus.d_out, bus.i_ff, bus.ar_ld_mem,
               bus.exec_en, bus.sc_err);
    end

    // Wrap: from T0, no exec_done for 16 edges -> T15 then wrap to T0.
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int k = 1; k < 16; k++) begin
      step();
      check($sformatf("wrap.t%0d", k), 32'(bus.t_out), 32'(16'h0001 << k));
      check($sformatf("wrap.err%0d", k), 32'(bus.sc_err), 32'd0);
    end
    step();
    check("wrap.t_out_after", 32'(bus.t_out),  32'h0001);
    check("wrap.sc_err_set",  32'(bus.sc_err), 32'd1);
    $display("txn wrap: t=%04h err=%0b", bus.t_out, bus.sc_err);
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    step();
    check("wrap.sc_err_sticky", 32'(bus.sc_err), 32'd1);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    check("wrap.halt_run",     32'(bus.run),    32'd0);
    check("wrap.halt_err",     32'(bus.sc_err), 32'd1);
    $display("txn sticky: run=%0b err=%0b", bus.run, bus.sc_err);

    // Asynchronous reset mid-run at T5.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    check("areset.pre_t5", 32'(bus.t_out), 32'h0020);
    #2 reset = 1'b1;
    #1;
    check("areset.run_now",  32'(bus.run),    32'd0);
    check("areset.t_now",    32'(bus.t_out),  32'd0);
    check("areset.d_now",    32'(bus.d_out),  32'd0);
    check("areset.err_now",  32'(bus.sc_err), 32'd0);
    check("areset.exec_now", 32'(bus.exec_en), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("areset.run_after", 32'(bus.run),   32'd0);
    check("areset.t_after",   32'(bus.t_out), 32'd0);
    $display("txn areset: run=%0b t=%04h d=%02h err=%0b",
             bus.run, bus.t_out, bus.d_out, bus.sc_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
